serializer_8b: RTL and testbench

SERIALIZER_8B -- requirements
Module: serializer_8b

---
 rtl/serializer_8b_pkg.sv | 12 +
 rtl/serializer_8b_encoder.sv | 96 +++++++++
 rtl/serializer_8b.sv | 91 +++++++++
 tb/tb_serializer_8b.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serializer_8b_pkg.sv
// rtl/serializer_8b_pkg.sv - shared constants for the 8b/10b serializer slice
// Contents:
//   MARKER_DEFAULT   raw 10-bit frame start/stop symbol
//   SYM_BITS_DEFAULT bits per transmitted symbol (only 10 is supported)
//   K_BIT            position of the control (K) flag in the encoder input word
package serializer_8b_pkg;

  localparam logic [9:0] MARKER_DEFAULT   = 10'h07E;
  localparam int         SYM_BITS_DEFAULT = 10;
  localparam int         K_BIT            = 8;

endpackage

// File: rtl/serializer_8b_encoder.sv
// rtl/serializer_8b_encoder.sv - combinational 8b/10b encoder
// Ports:
//   datain  [8:0] {K, HGF EDCBA}
//   dispin        running disparity in (0 = RD-, 1 = RD+)
//   dataout [9:0] {a b c d e i, f g h j}; bit 9 ('a') is sent first
//   dispout       running disparity after this symbol
module serializer_8b_encoder
  import serializer_8b_pkg::*;
(
  input  logic [8:0] datain,
  input  logic       dispin,
  output logic [9:0] dataout,
  output logic       dispout
);

  // RD- form of the 5b/6b code; the RD+ form is its complement where one exists
  function automatic logic [5:0] enc6(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:  r = 6'b100111;  5'd1:  r = 6'b011101;
      5'd2:  r = 6'b101101;  5'd3:  r = 6'b110001;
      5'd4:  r = 6'b110101;  5'd5:  r = 6'b101001;
      5'd6:  r = 6'b011001;  5'd7:  r = 6'b111000;
      5'd8:  r = 6'b111001;  5'd9:  r = 6'b100101;
      5'd10: r = 6'b010101;  5'd11: r = 6'b110100;
      5'd12: r = 6'b001101;  5'd13: r = 6'b101100;
      5'd14: r = 6'b011100;  5'd15: r = 6'b010111;
      5'd16: r = 6'b011011;  5'd17: r = 6'b100011;
      5'd18: r = 6'b010011;  5'd19: r = 6'b110010;
      5'd20: r = 6'b001011;  5'd21: r = 6'b101010;
      5'd22: r = 6'b011010;  5'd23: r = 6'b111010;
      5'd24: r = 6'b110011;  5'd25: r = 6'b100110;
      5'd26: r = 6'b010110;  5'd27: r = 6'b110110;
      5'd28: r = 6'b001110;  5'd29: r = 6'b101110;
      5'd30: r = 6'b011110;
      default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // RD- form of the 3b/4b code; alt7 selects the A7 variant that avoids a run of five
  function automatic logic [3:0] enc4(input logic [2:0] y, input logic alt7);
    logic [3:0] r;
    case (y)
      3'd0: r = 4'b1011;
      3'd1: r = 4'b1001;
      3'd2: r = 4'b0101;
      3'd3: r = 4'b1100;
      3'd4: r = 4'b1101;
      3'd5: r = 4'b1010;
      3'd6: r = 4'b0110;
      default: r = alt7 ? 4'b0111 : 4'b1110;
    endcase
    return r;
  endfunction

  logic       k;
  logic       k28;
  logic [4:0] x;
  logic [2:0] y;
  logic [5:0] c6_neg;
  logic [5:0] c6;
  logic [3:0] c4_neg;
  logic [3:0] c4;
  logic       rd6;
  logic       a7;

  assign k   = datain[K_BIT];
  assign x   = datain[4:0];
  assign y   = datain[7:5];
  assign k28 = k && (x == 5'd28);

  always_comb begin
    c6_neg = k28 ? 6'b001111 : enc6(x);
    // unbalanced codes and the balanced-but-biased D.07 flip under RD+
    c6 = c6_neg;
    if (dispin && (($countones(c6_neg) != 3) || (!k && (x == 5'd7))))
      c6 = ~c6_neg;
    rd6 = ($countones(c6_neg) != 3) ? ~dispin : dispin;

    a7 = (y == 3'd7) &&
         (k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               ( rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    c4_neg = enc4(y, a7);
    c4 = c4_neg;
    if (($countones(c4_neg) != 2) || (y == 3'd3))
      c4 = rd6 ? ~c4_neg : c4_neg;
    else if (k28)
      // K.28 inverts its balanced fghj whenever the 6b part left RD-
      c4 = rd6 ? c4_neg : ~c4_neg;

    dispout = ($countones(c4_neg) != 2) ? ~rd6 : rd6;
    dataout = {c6, c4};
  end

endmodule

// File: rtl/serializer_8b.sv
// rtl/serializer_8b.sv - byte to 8b/10b serial stream with marker framing
// Ports:
//   clk       clock, rising edge
//   reset     asynchronous active-high reset
//   data_i    byte to transmit
//   valid_i   data_i/last_i valid
//   last_i    final byte of a frame
//   ready_o   holding register empty, byte accepted when valid_i && ready_o
//   serial_o  serial bit stream, MSB of each symbol first
//   st_flag   high for the whole symbol while MARKER is on serial_o
module serializer_8b
  import serializer_8b_pkg::*;
#(
  parameter logic [9:0] MARKER   = MARKER_DEFAULT,
  parameter int         SYM_BITS = SYM_BITS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       last_i,
  output logic       ready_o,
  output logic       serial_o,
  output logic       st_flag
);

  localparam logic [3:0] LAST_BIT = 4'(SYM_BITS - 1);

  logic [9:0] sh;
  logic [3:0] bit_cnt;
  logic [7:0] hold_data;
  logic       hold_last;
  logic       hold_full;
  logic       gap_pend;
  logic       rd;
  logic [9:0] enc_out;
  logic       enc_disp;
  logic       boundary;
  logic       load_data;

  serializer_8b_encoder u_encoder (
    .datain  ({1'b0, hold_data}),
    .dispin  (rd),
    .dataout (enc_out),
    .dispout (enc_disp)
  );

  assign serial_o  = sh[9];
  assign ready_o   = !hold_full;
  assign boundary  = (bit_cnt == LAST_BIT);
  // a byte that ended a frame forces one marker before the next held byte
  assign load_data = hold_full && !gap_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh        <= MARKER;
      bit_cnt   <= 4'd0;
      hold_data <= 8'd0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      gap_pend  <= 1'b0;
      rd        <= 1'b0;
      st_flag   <= 1'b1;
    end else begin
      if (boundary) begin
        bit_cnt <= 4'd0;
        if (load_data) begin
          sh        <= enc_out;
          hold_full <= 1'b0;
          gap_pend  <= hold_last;
          rd        <= enc_disp;
          st_flag   <= 1'b0;
        end else begin
          sh       <= MARKER;
          gap_pend <= 1'b0;
          st_flag  <= 1'b1;
        end
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        sh      <= {sh[8:0], 1'b0};
      end
      // never coincides with the emptying load above: ready_o is low then
      if (valid_i && !hold_full) begin
        hold_data <= data_i;
        hold_last <= last_i;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serializer_8b.sv
// tb/tb_serializer_8b.sv - scoreboard bench for serializer_8b
module tb_serializer_8b;

  localparam logic [9:0] MARKER = 10'h07E;

  typedef struct packed {
    logic [9:0] sym;
    logic       last;
    logic       contig;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i;
  logic       last_i;
  logic       ready_o;
  logic       serial_o;
  logic       st_flag;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_markers = 0;
  int   n_data    = 0;

  serializer_8b #(.MARKER(MARKER), .SYM_BITS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .last_i   (last_i),
    .ready_o  (ready_o),
    .serial_o (serial_o),
    .st_flag  (st_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Called just after a negedge; ready_o seen now holds for the coming posedge.
  task automatic send(input logic [7:0] d, input logic l, input logic [9:0] sym,
                      input logic contig, input logic push, input logic keep_valid);
    int waited;
    waited  = 0;
    data_i  = d;
    last_i  = l;
    valid_i = 1'b1;
    while (!ready_o && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ready_o) begin
      check("ready_timeout", 32'(ready_o), 32'd1);
      valid_i = 1'b0;
    end else begin
      if (push) exp_q.push_back('{sym: sym, last: l, contig: contig});
      @(negedge clk);
      check("ready_drop_after_accept", 32'(ready_o), 32'd0);
      if (!keep_valid) valid_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (12) @(negedge clk);
  endtask

  // Monitor: assembles one symbol per 10 negedges, aligned to reset release.
  initial begin
    logic [9:0] cur;
    int         idx;
    logic       st_all1;
    logic       st_all0;
    logic       prev_data;
    logic       prev_last;
    exp_t       e;
    cur = '0; idx = 0; st_all1 = 1'b1; st_all0 = 1'b1;
    prev_data = 1'b0; prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        idx = 0; prev_data = 1'b0; prev_last = 1'b0;
        continue;
      end
      cur = {cur[8:0], serial_o};
      if (idx == 0) begin st_all1 = 1'b1; st_all0 = 1'b1; end
      st_all1 = st_all1 & st_flag;
      st_all0 = st_all0 & !st_flag;
      idx++;
      if (idx == 10) begin
        idx = 0;
        if (prev_last) check("marker_after_last", 32'(cur), 32'(MARKER));
        if (cur == MARKER) begin
          n_markers++;
          check("marker_st_flag", 32'(st_all1), 32'd1);
          prev_data = 1'b0;
          prev_last = 1'b0;
        end else begin
          n_data++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_data: got %h, required no data symbol", cur);
            prev_last = 1'b0;
          end else begin
            e = exp_q.pop_front();
            check("data_symbol", 32'(cur), 32'(e.sym));
            check("data_st_flag_low", 32'(st_all0), 32'd1);
            if (e.contig) check("contiguous", 32'(prev_data), 32'd1);
            prev_last = e.last;
          end
          prev_data = 1'b1;
        end
      end
    end
  end

  initial begin
    int data_before;
    int n;
    reset = 1'b1; valid_i = 1'b0; data_i = 8'h00; last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_serial", 32'(serial_o), 32'd0);
    check("reset_st_flag", 32'(st_flag), 32'd1);
    check("reset_ready", 32'(ready_o), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // idle: four whole markers in 40 clocks
    repeat (40) @(negedge clk);
    #1;
    check("idle_markers", 32'(n_markers), 32'd4);
    check("idle_no_data", 32'(n_data), 32'd0);
    check("idle_ready", 32'(ready_o), 32'd1);

    // single-byte frame: D.5.5 from RD- = 101001_1010
    send(8'hA5, 1'b1, 10'h29A, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // back-to-back frame 01,02,03(last) then 04(last) already held
    send(8'h01, 1'b0, 10'h1D4, 1'b0, 1'b1, 1'b1);  // D.1.0  RD-: 011101_0100
    send(8'h02, 1'b0, 10'h2D4, 1'b1, 1'b1, 1'b1);  // D.2.0  RD-: 101101_0100
    send(8'h03, 1'b1, 10'h31B, 1'b1, 1'b1, 1'b1);  // D.3.0  RD-: 110001_1011 -> RD+
    send(8'h04, 1'b1, 10'h0AB, 1'b0, 1'b1, 1'b0);  // D.4.0  RD+: 001010_1011 -> RD+
    wait_drain();

    // junk on valid_i/data_i while ready_o=0 must be ignored
    send(8'h55, 1'b0, 10'h2A5, 1'b0, 1'b1, 1'b0);  // D.21.2 RD+: 101010_0101
    n = 0;
    while (!ready_o && n < 40) begin
      valid_i = n[0];
      data_i  = 8'(n * 37 + 8'h9C);
      last_i  = n[1];
      @(negedge clk);
      n++;
    end
    valid_i = 1'b0;
    send(8'h00, 1'b1, 10'h18B, 1'b1, 1'b1, 1'b0);  // D.0.0  RD+: 011000_1011
    wait_drain();

    // reset at bit 4 of a data symbol with another byte held
    send(8'h33, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
    send(8'h44, 1'b1, 10'h000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("queue_empty_before_reset", 32'(exp_q.size()), 32'd0);
    data_before = n_data;
    #2 reset = 1'b1;
    #1;
    check("async_reset_serial", 32'(serial_o), 32'd0);
    check("async_reset_st_flag", 32'(st_flag), 32'd1);
    check("async_reset_ready", 32'(ready_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("held_byte_dropped", 32'(n_data), 32'(data_before));
    check("post_reset_ready", 32'(ready_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
